// File: rtl/asym_fifo_pkg.sv
// Shared constants and helpers for the asymmetric FIFO controllers.
// Width math is evaluated at elaboration time only.
package asym_fifo_pkg;

    localparam int BO_MS_FIRST = 0;
    localparam int BO_LS_FIRST = 1;

    localparam int ERR_STICKY = 0;
    localparam int ERR_PULSE  = 1;

    // Bits needed to encode value distinct codes; never returns less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/asym_fifo_flag_gen.sv
// Status flags decoded from the registered word count.
// Shared by the packing and unpacking FIFO controllers.
module asym_fifo_flag_gen #(
    parameter int depth    = 8,
    parameter int ae_level = 2,
    parameter int af_level = 2,
    parameter int CW       = 4
) (
    input  logic [CW-1:0] wcount,
    output logic          empty,
    output logic          almost_empty,
    output logic          half_full,
    output logic          almost_full,
    output logic          full
);

    assign empty        = (wcount == CW'(0));
    assign full         = (wcount == CW'(depth));
    assign almost_empty = (wcount <= CW'(ae_level));
    assign almost_full  = (wcount >= CW'(depth - af_level));
    assign half_full    = (wcount >= CW'((depth + 1) / 2));

endmodule

// File: rtl/asym_fifoctl_unpack_s1.sv
// Wide-write / narrow-read FIFO controller for an external async-read RAM.
// Each stored word is popped as K sub-words; the word retires on the last one.
module asym_fifoctl_unpack_s1
    import asym_fifo_pkg::*;
#(
    parameter int data_in_width  = 16,
    parameter int data_out_width = 8,
    parameter int depth          = 8,
    parameter int ae_level       = 2,
    parameter int af_level       = 2,
    parameter int err_mode       = 1,
    parameter int byte_order     = 0,
    localparam int AW            = clog2(depth)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_req_n,
    input  logic                      pop_req_n,
    input  logic [data_in_width-1:0]  data_in,
    input  logic [data_in_width-1:0]  rd_data,
    output logic                      we_n,
    output logic [AW-1:0]             wr_addr,
    output logic [data_in_width-1:0]  wr_data,
    output logic [AW-1:0]             rd_addr,
    output logic [data_out_width-1:0] data_out,
    output logic                      empty,
    output logic                      almost_empty,
    output logic                      half_full,
    output logic                      almost_full,
    output logic                      full,
    output logic                      part_wd,
    output logic                      error
);

    localparam int K  = data_in_width / data_out_width;
    localparam int CW = clog2(depth + 1);
    localparam int SW = clog2(K);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] wcount_q, wcount_d;
    logic [SW-1:0] sub_idx_q, sub_idx_d;
    logic          err_q, err_d;

    logic          push_ok;
    logic          pop_ok;
    logic          retire;
    logic          err_event;
    logic [SW-1:0] sub_sel;

    asym_fifo_flag_gen #(
        .depth    (depth),
        .ae_level (ae_level),
        .af_level (af_level),
        .CW       (CW)
    ) u_flags (
        .wcount       (wcount_q),
        .empty        (empty),
        .almost_empty (almost_empty),
        .half_full    (half_full),
        .almost_full  (almost_full),
        .full         (full)
    );

    always_comb begin
        push_ok   = !push_req_n && !full;
        pop_ok    = !pop_req_n && !empty;
        retire    = pop_ok && (sub_idx_q == SW'(K - 1));
        err_event = (!push_req_n && full) || (!pop_req_n && empty);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        sub_idx_d = sub_idx_q;

        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == AW'(depth - 1)) ? '0 : wr_ptr_q + AW'(1);
        end

        if (pop_ok) begin
            if (retire) begin
                sub_idx_d = '0;
                rd_ptr_d  = (rd_ptr_q == AW'(depth - 1)) ? '0 : rd_ptr_q + AW'(1);
            end else begin
                sub_idx_d = sub_idx_q + SW'(1);
            end
        end

        wcount_d = wcount_q + CW'(push_ok) - CW'(retire);

        if (err_mode == ERR_STICKY) begin
            err_d = err_q || err_event;
        end else begin
            err_d = err_event;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wcount_q  <= '0;
            sub_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wcount_q  <= wcount_d;
            sub_idx_q <= sub_idx_d;
            err_q     <= err_d;
        end
    end

    // MS-first counts sub-words down from the top of the stored word.
    always_comb begin
        if (byte_order == BO_LS_FIRST) begin
            sub_sel = sub_idx_q;
        end else begin
            sub_sel = SW'(K - 1) - sub_idx_q;
        end
        data_out = rd_data[int'(sub_sel) * data_out_width +: data_out_width];
    end

    assign we_n    = !push_ok;
    assign wr_addr = wr_ptr_q;
    assign wr_data = data_in;
    assign rd_addr = rd_ptr_q;
    assign part_wd = (sub_idx_q != '0);
    assign error   = err_q;

endmodule

// File: tb/tb_asym_fifoctl_unpack_s1.sv
// Directed bench: instance A uses defaults (depth 8, pulse error, MS first),
// instance B uses depth 6, sticky error, LS first. Each has its own RAM model.
module tb_asym_fifoctl_unpack_s1;

    logic clk = 1'b0;
    logic rst;
    int   ncmp = 0;
    int   nerr = 0;

    logic        push_req_n_a, pop_req_n_a;
    logic [15:0] data_in_a, rd_data_a, wr_data_a;
    logic        we_n_a;
    logic [2:0]  wr_addr_a, rd_addr_a;
    logic [7:0]  data_out_a;
    logic        empty_a, almost_empty_a, half_full_a, almost_full_a, full_a, part_wd_a, error_a;

    logic        push_req_n_b, pop_req_n_b;
    logic [15:0] data_in_b, rd_data_b, wr_data_b;
    logic        we_n_b;
    logic [2:0]  wr_addr_b, rd_addr_b;
    logic [7:0]  data_out_b;
    logic        empty_b, almost_empty_b, half_full_b, almost_full_b, full_b, part_wd_b, error_b;

    logic [15:0] mem_a [8];
    logic [15:0] mem_b [6];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!we_n_a) mem_a[wr_addr_a] <= wr_data_a;
        if (!we_n_b) mem_b[wr_addr_b] <= wr_data_b;
    end
    assign rd_data_a = mem_a[rd_addr_a];
    assign rd_data_b = mem_b[rd_addr_b];

    asym_fifoctl_unpack_s1 u_dut_a (
        .clk(clk), .rst(rst), .push_req_n(push_req_n_a), .pop_req_n(pop_req_n_a),
        .data_in(data_in_a), .rd_data(rd_data_a), .we_n(we_n_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .rd_addr(rd_addr_a), .data_out(data_out_a), .empty(empty_a),
        .almost_empty(almost_empty_a), .half_full(half_full_a), .almost_full(almost_full_a),
        .full(full_a), .part_wd(part_wd_a), .error(error_a)
    );

    asym_fifoctl_unpack_s1 #(
        .depth(6), .err_mode(0), .byte_order(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .push_req_n(push_req_n_b), .pop_req_n(pop_req_n_b),
        .data_in(data_in_b), .rd_data(rd_data_b), .we_n(we_n_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .rd_addr(rd_addr_b), .data_out(data_out_b), .empty(empty_b),
        .almost_empty(almost_empty_b), .half_full(half_full_b), .almost_full(almost_full_b),
        .full(full_b), .part_wd(part_wd_b), .error(error_b)
    );

    task automatic set_a(input bit p, input bit q, input logic [15:0] d);
        push_req_n_a = !p; pop_req_n_a = !q; data_in_a = d; #1;
    endtask

    task automatic set_b(input bit p, input bit q, input logic [15:0] d);
        push_req_n_b = !p; pop_req_n_b = !q; data_in_b = d; #1;
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        set_a(0, 0, 16'h0); set_b(0, 0, 16'h0);
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push_req_n_a = 1'b1; pop_req_n_a = 1'b1; data_in_a = '0;
        push_req_n_b = 1'b1; pop_req_n_b = 1'b1; data_in_b = '0;
        #3;
        ncmp++; if (empty_a !== 1'b1) begin nerr++; $display("FAIL rst_empty: got %b want 1", empty_a); end
        ncmp++; if (almost_empty_a !== 1'b1) begin nerr++; $display("FAIL rst_almost_empty: got %b want 1", almost_empty_a); end
        ncmp++; if ({half_full_a, almost_full_a, full_a, part_wd_a, error_a} !== 5'b0) begin
            nerr++; $display("FAIL rst_flags: got %b want 00000", {half_full_a, almost_full_a, full_a, part_wd_a, error_a}); end
        ncmp++; if (we_n_a !== 1'b1) begin nerr++; $display("FAIL rst_we_n: got %b want 1", we_n_a); end
        ncmp++; if ({wr_addr_a, rd_addr_a} !== 6'b0) begin nerr++; $display("FAIL rst_addr: got %h want 0", {wr_addr_a, rd_addr_a}); end
        ncmp++; if ({empty_b, error_b, full_b} !== 3'b100) begin nerr++; $display("FAIL rst_b_flags: got %b want 100", {empty_b, error_b, full_b}); end
        @(negedge clk); rst = 1'b0; #1;
        // Build up mid-operation state: 3 words, head word half consumed.
        for (int i = 0; i < 3; i++) begin set_a(1, 0, 16'h1000 + 16'(i)); tick(); end
        set_a(0, 1, 16'h0); tick();
        set_a(0, 0, 16'h0);
        ncmp++; if (part_wd_a !== 1'b1) begin nerr++; $display("FAIL mid_part_wd: got %b want 1", part_wd_a); end
        ncmp++; if (almost_empty_a !== 1'b0) begin nerr++; $display("FAIL mid_almost_empty: got %b want 0", almost_empty_a); end
        rst = 1'b1; #1;
        ncmp++; if (empty_a !== 1'b1) begin nerr++; $display("FAIL async_rst_empty: got %b want 1", empty_a); end
        ncmp++; if (almost_empty_a !== 1'b1) begin nerr++; $display("FAIL async_rst_almost_empty: got %b want 1", almost_empty_a); end
        ncmp++; if (part_wd_a !== 1'b0) begin nerr++; $display("FAIL async_rst_part_wd: got %b want 0", part_wd_a); end
        ncmp++; if (rd_addr_a !== 3'd0) begin nerr++; $display("FAIL async_rst_rd_addr: got %0d want 0", rd_addr_a); end
        ncmp++; if (wr_addr_a !== 3'd0) begin nerr++; $display("FAIL async_rst_wr_addr: got %0d want 0", wr_addr_a); end
        ncmp++; if (error_a !== 1'b0) begin nerr++; $display("FAIL async_rst_error: got %b want 0", error_a); end
        @(negedge clk); rst = 1'b0; #1;
    endtask

    task automatic test_unpack_ms();
        do_reset();
        set_a(1, 0, 16'hA1B2);
        ncmp++; if (we_n_a !== 1'b0) begin nerr++; $display("FAIL ms_we_n: got %b want 0", we_n_a); end
        ncmp++; if (wr_data_a !== 16'hA1B2) begin nerr++; $display("FAIL ms_wr_data: got %h want a1b2", wr_data_a); end
        tick();
        set_a(0, 1, 16'h0);
        ncmp++; if (data_out_a !== 8'hA1) begin nerr++; $display("FAIL ms_first: got %h want a1", data_out_a); end
        ncmp++; if (part_wd_a !== 1'b0) begin nerr++; $display("FAIL ms_part0: got %b want 0", part_wd_a); end
        tick();
        ncmp++; if (part_wd_a !== 1'b1) begin nerr++; $display("FAIL ms_part1: got %b want 1", part_wd_a); end
        ncmp++; if (data_out_a !== 8'hB2) begin nerr++; $display("FAIL ms_second: got %h want b2", data_out_a); end
        tick();
        set_a(0, 0, 16'h0);
        ncmp++; if (empty_a !== 1'b1) begin nerr++; $display("FAIL ms_empty_after: got %b want 1", empty_a); end
        ncmp++; if (rd_addr_a !== 3'd1) begin nerr++; $display("FAIL ms_rd_addr: got %0d want 1", rd_addr_a); end
        ncmp++; if (part_wd_a !== 1'b0) begin nerr++; $display("FAIL ms_part_after: got %b want 0", part_wd_a); end
    endtask

    task automatic test_unpack_ls();
        do_reset();
        set_b(1, 0, 16'hA1B2); tick();
        set_b(0, 1, 16'h0);
        ncmp++; if (data_out_b !== 8'hB2) begin nerr++; $display("FAIL ls_first: got %h want b2", data_out_b); end
        tick();
        ncmp++; if (data_out_b !== 8'hA1) begin nerr++; $display("FAIL ls_second: got %h want a1", data_out_b); end
        tick();
        set_b(0, 0, 16'h0);
        ncmp++; if (empty_b !== 1'b1) begin nerr++; $display("FAIL ls_empty_after: got %b want 1", empty_b); end
        ncmp++; if (rd_addr_b !== 3'd1) begin nerr++; $display("FAIL ls_rd_addr: got %0d want 1", rd_addr_b); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_a(1, 0, 16'h0100 + 16'(i));
            ncmp++; if (we_n_a !== 1'b0) begin nerr++; $display("FAIL full_we_n[%0d]: got %b want 0", i, we_n_a); end
            tick();
            ncmp++; if (almost_full_a !== (i + 1 >= 6)) begin nerr++; $display("FAIL almost_full[%0d]: got %b want %b", i + 1, almost_full_a, (i + 1 >= 6)); end
            ncmp++; if (full_a !== (i + 1 == 8)) begin nerr++; $display("FAIL full[%0d]: got %b want %b", i + 1, full_a, (i + 1 == 8)); end
            ncmp++; if (half_full_a !== (i + 1 >= 4)) begin nerr++; $display("FAIL half_full[%0d]: got %b want %b", i + 1, half_full_a, (i + 1 >= 4)); end
        end
        set_a(1, 0, 16'hDEAD);
        ncmp++; if (we_n_a !== 1'b1) begin nerr++; $display("FAIL ovf_we_n: got %b want 1", we_n_a); end
        ncmp++; if (wr_addr_a !== 3'd0) begin nerr++; $display("FAIL ovf_wr_addr: got %0d want 0", wr_addr_a); end
        tick();
        set_a(0, 0, 16'h0);
        ncmp++; if (error_a !== 1'b1) begin nerr++; $display("FAIL ovf_error_pulse: got %b want 1", error_a); end
        ncmp++; if ({full_a, wr_addr_a} !== 4'b1000) begin nerr++; $display("FAIL ovf_state: got %b want 1000", {full_a, wr_addr_a}); end
        tick();
        ncmp++; if (error_a !== 1'b0) begin nerr++; $display("FAIL ovf_error_clear: got %b want 0", error_a); end
        // Push while full with a retiring pop in the same cycle: push still rejected.
        set_a(0, 1, 16'h0); tick();
        set_a(1, 1, 16'hBEEF);
        ncmp++; if (we_n_a !== 1'b1) begin nerr++; $display("FAIL full_retire_we_n: got %b want 1", we_n_a); end
        ncmp++; if (data_out_a !== 8'h00) begin nerr++; $display("FAIL full_retire_data: got %h want 00", data_out_a); end
        tick();
        set_a(0, 0, 16'h0);
        ncmp++; if ({full_a, almost_full_a} !== 2'b01) begin nerr++; $display("FAIL full_retire_flags: got %b want 01", {full_a, almost_full_a}); end
        ncmp++; if (error_a !== 1'b1) begin nerr++; $display("FAIL full_retire_error: got %b want 1", error_a); end
        ncmp++; if (data_out_a !== 8'h01) begin nerr++; $display("FAIL full_retire_next: got %h want 01", data_out_a); end
        tick();
        ncmp++; if (error_a !== 1'b0) begin nerr++; $display("FAIL full_retire_error_clear: got %b want 0", error_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin set_a(1, 0, 16'h3000 + 16'(i)); tick(); end
        set_a(0, 1, 16'h0); tick();
        set_a(1, 1, 16'h3333);
        ncmp++; if (we_n_a !== 1'b0) begin nerr++; $display("FAIL b2b_we_n: got %b want 0", we_n_a); end
        ncmp++; if (wr_addr_a !== 3'd3) begin nerr++; $display("FAIL b2b_wr_addr_before: got %0d want 3", wr_addr_a); end
        tick();
        set_a(0, 0, 16'h0);
        ncmp++; if ({wr_addr_a, rd_addr_a} !== {3'd4, 3'd1}) begin nerr++; $display("FAIL b2b_ptrs: got %0d/%0d want 4/1", wr_addr_a, rd_addr_a); end
        ncmp++; if (part_wd_a !== 1'b0) begin nerr++; $display("FAIL b2b_part_wd: got %b want 0", part_wd_a); end
        ncmp++; if ({empty_a, almost_empty_a, half_full_a} !== 3'b000) begin nerr++; $display("FAIL b2b_count3: got %b want 000", {empty_a, almost_empty_a, half_full_a}); end
        ncmp++; if (data_out_a !== 8'h30) begin nerr++; $display("FAIL b2b_data: got %h want 30", data_out_a); end
    endtask

    task automatic test_sticky_error();
        do_reset();
        set_b(1, 1, 16'h5A5A);
        ncmp++; if (we_n_b !== 1'b0) begin nerr++; $display("FAIL sticky_push_ok: got %b want 0", we_n_b); end
        tick();
        set_b(0, 0, 16'h0);
        ncmp++; if (error_b !== 1'b1) begin nerr++; $display("FAIL sticky_set: got %b want 1", error_b); end
        ncmp++; if ({empty_b, part_wd_b} !== 2'b00) begin nerr++; $display("FAIL sticky_pop_rejected: got %b want 00", {empty_b, part_wd_b}); end
        set_b(0, 1, 16'h0);
        ncmp++; if (data_out_b !== 8'h5A) begin nerr++; $display("FAIL sticky_data: got %h want 5a", data_out_b); end
        tick(); tick();
        set_b(1, 0, 16'h1234); tick();
        set_b(0, 0, 16'h0); tick();
        ncmp++; if (error_b !== 1'b1) begin nerr++; $display("FAIL sticky_hold: got %b want 1", error_b); end
        ncmp++; if (empty_b !== 1'b0) begin nerr++; $display("FAIL sticky_traffic: got %b want 0", empty_b); end
        do_reset();
        ncmp++; if (error_b !== 1'b0) begin nerr++; $display("FAIL sticky_rst_clear: got %b want 0", error_b); end
    endtask

    task automatic test_wrap();
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            w = {8'(i * 16 + 5), 8'(8'hC0 + i)};
            set_b(1, 0, w);
            ncmp++; if (wr_addr_b !== 3'(i % 6)) begin nerr++; $display("FAIL wrap_wr_addr[%0d]: got %0d want %0d", i, wr_addr_b, i % 6); end
            tick();
            set_b(0, 1, 16'h0);
            ncmp++; if (rd_addr_b !== 3'(i % 6)) begin nerr++; $display("FAIL wrap_rd_addr[%0d]: got %0d want %0d", i, rd_addr_b, i % 6); end
            ncmp++; if (data_out_b !== w[7:0]) begin nerr++; $display("FAIL wrap_lo[%0d]: got %h want %h", i, data_out_b, w[7:0]); end
            tick();
            ncmp++; if (data_out_b !== w[15:8]) begin nerr++; $display("FAIL wrap_hi[%0d]: got %h want %h", i, data_out_b, w[15:8]); end
            tick();
            set_b(0, 0, 16'h0);
            ncmp++; if ({error_b, empty_b} !== 2'b01) begin nerr++; $display("FAIL wrap_state[%0d]: got %b want 01", i, {error_b, empty_b}); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unpack_ms();
        test_unpack_ls();
        test_full();
        test_back_to_back();
        test_sticky_error();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
